// File: rtl/ai_sched_pkg.sv
// Shared types and constants for the AI job scheduler: FSM states, core register
// addresses and bus widths.
package ai_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_FIRED,
        WR_HITS,
        WR_SHIPS,
        WR_START,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    localparam logic [1:0] AI_ADDR_START = 2'd0;
    localparam logic [1:0] AI_ADDR_FIRED = 2'd1;
    localparam logic [1:0] AI_ADDR_HITS  = 2'd2;
    localparam logic [1:0] AI_ADDR_SHIPS = 2'd3;

    localparam int BOARD_W  = 100;
    localparam int RESULT_W = 104;
    localparam int SHIPS_W  = 5;

endpackage

// File: rtl/ai_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr,
// wrapping modulo NUM_REQ, and returns it as one-hot grant plus index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    logic             found;
    int               cand;
    logic [IDX_W-1:0] cidx;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            cidx = IDX_W'(cand);
            if (!found && req[cidx]) begin
                found       = 1'b1;
                grant[cidx] = 1'b1;
                index       = cidx;
            end
        end
    end

endmodule

// File: rtl/ai_job_scheduler.sv
// Shares one AI probability-density core between NUM_REQ requesters: round-robin
// grant, four-beat register load, wait for completion, return result; watchdog aborts.
module ai_job_scheduler
    import ai_sched_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*BOARD_W-1:0]  req_fired,
    input  logic [NUM_REQ*BOARD_W-1:0]  req_hits,
    input  logic [NUM_REQ*SHIPS_W-1:0]  req_ships,
    output logic [NUM_REQ-1:0]          resp_done,
    output logic                        resp_err,
    output logic [RESULT_W-1:0]         resp_data,
    output logic                        busy,
    output logic [1:0]                  ai_addr,
    output logic                        ai_write_en,
    output logic [BOARD_W-1:0]          ai_data_in,
    input  logic                        ai_wait_request,
    input  logic [RESULT_W-1:0]         ai_data_out
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    state_t               state, state_nx;
    logic [IDX_W-1:0]     rr_ptr, grant_idx, arb_idx;
    logic [NUM_REQ-1:0]   arb_grant;
    logic [BOARD_W-1:0]   fired_lat, hits_lat, sel_fired, sel_hits;
    logic [SHIPS_W-1:0]   ships_lat, sel_ships;
    logic [WD_W-1:0]      wd_cnt;
    logic                 wd_expired;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .index (arb_idx)
    );

    // One-hot mux of the granted requester's job inputs
    always_comb begin
        sel_fired = '0;
        sel_hits  = '0;
        sel_ships = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_fired = req_fired[i*BOARD_W +: BOARD_W];
                sel_hits  = req_hits[i*BOARD_W +: BOARD_W];
                sel_ships = req_ships[i*SHIPS_W +: SHIPS_W];
            end
        end
    end

    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign resp_done  = (state == RESP) ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_nx    = state;
        ai_write_en = 1'b0;
        ai_addr     = AI_ADDR_START;
        ai_data_in  = '0;
        case (state)
            IDLE: if (|arb_grant) state_nx = WR_FIRED;
            WR_FIRED: begin
                ai_write_en = 1'b1;
                ai_addr     = AI_ADDR_FIRED;
                ai_data_in  = fired_lat;
                if (!ai_wait_request) state_nx = WR_HITS;
            end
            WR_HITS: begin
                ai_write_en = 1'b1;
                ai_addr     = AI_ADDR_HITS;
                ai_data_in  = hits_lat;
                if (!ai_wait_request) state_nx = WR_SHIPS;
            end
            WR_SHIPS: begin
                ai_write_en = 1'b1;
                ai_addr     = AI_ADDR_SHIPS;
                ai_data_in  = {{(BOARD_W-SHIPS_W){1'b0}}, ships_lat};
                if (!ai_wait_request) state_nx = WR_START;
            end
            WR_START: begin
                ai_write_en = 1'b1;
                ai_addr     = AI_ADDR_START;
                if (!ai_wait_request) state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (wd_expired)           state_nx = RESP;
                else if (ai_wait_request) state_nx = WAIT_DONE;
            end
            // A completion that coincides with expiry is reported as a normal result
            WAIT_DONE: if (!ai_wait_request || wd_expired) state_nx = RESP;
            RESP:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            fired_lat <= '0;
            hits_lat  <= '0;
            ships_lat <= '0;
            wd_cnt    <= '0;
            busy      <= 1'b0;
            resp_err  <= 1'b0;
            resp_data <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (|arb_grant) begin
                        grant_idx <= arb_idx;
                        fired_lat <= sel_fired;
                        hits_lat  <= sel_hits;
                        ships_lat <= sel_ships;
                        busy      <= 1'b1;
                    end
                end
                WR_START: if (!ai_wait_request) wd_cnt <= '0;
                WAIT_BUSY: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (wd_expired) begin
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                    end
                end
                WAIT_DONE: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (!ai_wait_request) begin
                        resp_err  <= 1'b0;
                        resp_data <= ai_data_out;
                    end else if (wd_expired) begin
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                    end
                end
                RESP: begin
                    rr_ptr   <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
                    busy     <= 1'b0;
                    resp_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
